// File: rtl/spi_master.sv
// Wishbone-mapped SPI mode-0 controller, one byte per DATA write, MSB first.
// Ack one cycle after accept; DATA/CONTROL writes stall while a byte is in flight, reads never stall.
module spi_master #(
  parameter int                       WB_ADDR_WIDTH = 20,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = 20'h0E800,
  parameter int                       CLK_DIV       = 4
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_ni,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [7:0]               wb_data_i,
  output logic [7:0]               wb_data_o,
  input  logic                     wb_we_i,
  input  logic                     wb_cycle_i,
  input  logic                     wb_strobe_i,
  output logic                     wb_stall_o,
  output logic                     wb_ack_o,
  output logic                     spi_cs_no,
  output logic                     spi_sck_o,
  output logic                     spi_sd_o,
  input  logic                     spi_sd_i,
  output logic                     busy_o
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] tx_shift, rx_shift, rx_data, div_cnt, rd_dat;
  logic [2:0] bit_cnt;
  logic [1:0] offset;
  logic       rx_valid, cs_en, busy;
  logic       sel, accept, wr_data, wr_ctrl, rd_data;
  logic       load, rise, fall, next_bit, done;

  assign offset     = wb_addr_i[1:0];
  assign sel        = wb_cycle_i & wb_strobe_i &
                      (wb_addr_i[WB_ADDR_WIDTH-1:2] == BASE_ADDR[WB_ADDR_WIDTH-1:2]);
  assign busy       = (state != IDLE);
  // Holding DATA and CONTROL writes keeps tx and CS stable for the whole byte.
  assign wb_stall_o = sel & busy & wb_we_i & ((offset == 2'd0) | (offset == 2'd2));
  assign accept     = sel & ~wb_stall_o;
  assign wr_data    = accept & wb_we_i & (offset == 2'd0);
  assign wr_ctrl    = accept & wb_we_i & (offset == 2'd2);
  assign rd_data    = accept & ~wb_we_i & (offset == 2'd0);
  assign busy_o     = busy;
  assign spi_cs_no  = ~cs_en;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    rise      = 1'b0;
    fall      = 1'b0;
    next_bit  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (wr_data) begin
        state_nxt = LOW;
        load      = 1'b1;
      end
      LOW: if (div_cnt == 8'd0) begin
        state_nxt = HIGH;
        rise      = 1'b1;
      end
      HIGH: if (div_cnt == 8'd0) begin
        fall = 1'b1;
        if (bit_cnt == 3'd7) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end else begin
          state_nxt = LOW;
          next_bit  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_dat = 8'h00;
    case (offset)
      2'd0:    rd_dat = rx_data;
      2'd1:    rd_dat = {6'b0, rx_valid, busy};
      2'd2:    rd_dat = {7'b0, cs_en};
      default: rd_dat = 8'h00;
    endcase
  end

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) state <= IDLE;
    else              state <= state_nxt;
  end

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      div_cnt   <= 8'd0;
      tx_shift  <= 8'h00;
      rx_shift  <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      bit_cnt   <= 3'd0;
      cs_en     <= 1'b0;
      spi_sck_o <= 1'b0;
      spi_sd_o  <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_data_o <= 8'h00;
    end else begin
      if (load | rise | next_bit) div_cnt <= DIV_RELOAD;
      else if (div_cnt != 8'd0)   div_cnt <= div_cnt - 8'd1;

      if (load) begin
        tx_shift <= wb_data_i;
        spi_sd_o <= wb_data_i[7];
        bit_cnt  <= 3'd0;
      end else if (next_bit) begin
        tx_shift <= tx_shift << 1;
        spi_sd_o <= tx_shift[6];
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if (rise) begin
        spi_sck_o <= 1'b1;
        rx_shift  <= {rx_shift[6:0], spi_sd_i};
      end else if (fall) begin
        spi_sck_o <= 1'b0;
      end

      // A completing byte wins over a same-cycle DATA read clearing rx_valid.
      if (done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end

      if (wr_ctrl) cs_en <= wb_data_i[0];

      wb_ack_o  <= accept;
      wb_data_o <= (accept & ~wb_we_i) ? rd_dat : 8'h00;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench: two spi_master instances (CLK_DIV 4 and 1) on one Wishbone bus, checked each cycle
// against a timeline model of the SPI byte, plus directed literal checks.
module tb_spi_master;

  localparam logic [19:0] BASE4 = 20'h0E800;
  localparam logic [19:0] BASE1 = 20'h0E900;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] adr;
  logic [7:0]  wdat;
  logic        we, cyc, stb;
  logic [7:0]  dat4, dat1;
  logic        stall4, stall1, ack4, ack1, cs4, cs1, sck4, sck1, sd4, sd1, busy4, busy1;
  logic        sdi4, sdi1;
  bit          loop4 = 1'b0;
  int          sd1_mode = 0;

  always #5 clk = ~clk;

  spi_master #(.WB_ADDR_WIDTH(20), .BASE_ADDR(BASE4), .CLK_DIV(4)) dut4 (
    .wb_clock_i(clk), .wb_reset_ni(rst_n), .wb_addr_i(adr), .wb_data_i(wdat),
    .wb_data_o(dat4), .wb_we_i(we), .wb_cycle_i(cyc), .wb_strobe_i(stb),
    .wb_stall_o(stall4), .wb_ack_o(ack4), .spi_cs_no(cs4), .spi_sck_o(sck4),
    .spi_sd_o(sd4), .spi_sd_i(sdi4), .busy_o(busy4));

  spi_master #(.WB_ADDR_WIDTH(20), .BASE_ADDR(BASE1), .CLK_DIV(1)) dut1 (
    .wb_clock_i(clk), .wb_reset_ni(rst_n), .wb_addr_i(adr), .wb_data_i(wdat),
    .wb_data_o(dat1), .wb_we_i(we), .wb_cycle_i(cyc), .wb_strobe_i(stb),
    .wb_stall_o(stall1), .wb_ack_o(ack1), .spi_cs_no(cs1), .spi_sck_o(sck1),
    .spi_sd_o(sd1), .spi_sd_i(sdi1), .busy_o(busy1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // CIPO stimulus: random, loopback, or tied, updated just after each rising clock edge.
  initial begin
    sdi4 = 1'b0;
    sdi1 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sdi4 = loop4 ? sd4 : 1'($urandom);
      sdi1 = (sd1_mode == 0) ? 1'($urandom) : (sd1_mode == 2);
    end
  end

  int          rise4 = 0, rise1 = 0, bcnt4 = 0, bcnt1 = 0;
  logic [7:0]  rbits4 = 8'h00;
  always @(posedge sck4) begin
    rise4++;
    rbits4 = {rbits4[6:0], sd4};
  end
  always @(posedge sck1) rise1++;
  always @(negedge clk) begin
    if (busy4) bcnt4++;
    if (busy1) bcnt1++;
  end

  // Model: a byte occupies cycles j = 0 .. 16*D-1 after its accepting edge;
  // half-period h = j/D, SCK high on odd h, COPI carries bit 7-h/2.
  bit         m_act[2], m_rxv[2], m_cs[2], m_lsd[2], m_ack[2];
  int         m_j[2];
  logic [7:0] m_b[2], m_rxa[2], m_rxd[2], m_dat[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin : cmp
      int         d, h;
      bit         s, st, acc, sdi;
      logic [1:0] off;
      logic [7:0] rv;
      logic [19:0] ba;
      string      p;
      d   = (i == 0) ? 4 : 1;
      ba  = (i == 0) ? BASE4 : BASE1;
      sdi = (i == 0) ? sdi4 : sdi1;
      p   = (i == 0) ? "div4" : "div1";
      if (!rst_n) begin
        m_act[i] = 0; m_j[i] = 0; m_rxv[i] = 0; m_cs[i] = 0; m_lsd[i] = 0;
        m_ack[i] = 0; m_rxa[i] = 8'h00; m_rxd[i] = 8'h00; m_dat[i] = 8'h00; m_b[i] = 8'h00;
      end
      h   = m_j[i] / d;
      off = adr[1:0];
      s   = cyc && stb && (adr[19:2] == ba[19:2]);
      st  = s && m_act[i] && we && (off == 2'd0 || off == 2'd2);
      chk({p, " busy"},  (i == 0) ? busy4 : busy1, m_act[i]);
      chk({p, " sck"},   (i == 0) ? sck4 : sck1, m_act[i] && (h % 2 == 1));
      chk({p, " sd"},    (i == 0) ? sd4 : sd1, m_act[i] ? m_b[i][7 - h / 2] : m_lsd[i]);
      chk({p, " cs_n"},  (i == 0) ? cs4 : cs1, !m_cs[i]);
      chk({p, " stall"}, (i == 0) ? stall4 : stall1, st);
      chk({p, " ack"},   (i == 0) ? ack4 : ack1, m_ack[i]);
      chk({p, " rdata"}, (i == 0) ? dat4 : dat1, m_dat[i]);
      if (rst_n) begin
        acc = s && !st;
        case (off)
          2'd0:    rv = m_rxd[i];
          2'd1:    rv = {6'b0, m_rxv[i], m_act[i]};
          2'd2:    rv = {7'b0, m_cs[i]};
          default: rv = 8'h00;
        endcase
        m_ack[i] = acc;
        m_dat[i] = (acc && !we) ? rv : 8'h00;
        if (m_act[i] && (m_j[i] % (2 * d)) == d - 1) m_rxa[i] = {m_rxa[i][6:0], sdi};
        if (acc && !we && off == 2'd0) m_rxv[i] = 0;
        if (m_act[i]) begin
          m_j[i]++;
          if (m_j[i] == 16 * d) begin
            m_act[i] = 0; m_j[i] = 0; m_rxd[i] = m_rxa[i]; m_rxv[i] = 1; m_lsd[i] = m_b[i][0];
          end
        end
        if (acc && we && off == 2'd0) begin m_act[i] = 1; m_j[i] = 0; m_b[i] = wdat; end
        if (acc && we && off == 2'd2) m_cs[i] = wdat[0];
      end
    end
  end

  // Presents a request and returns just after the edge that accepts it.
  task automatic wb_issue(input logic [19:0] a, input bit w, input logic [7:0] d, output int stalls);
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = d;
    stalls = 0;
    @(negedge clk);
    while ((stall4 || stall1) && stalls < 300) begin
      stalls++;
      @(negedge clk);
    end
    chk("stall bound", int'(stalls < 300), 1);
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wb_read(input logic [19:0] a, output logic [7:0] d);
    int s;
    wb_issue(a, 1'b0, 8'h00, s);
    @(negedge clk);
    chk("read ack", ack4 || ack1, 1);
    d = dat4 | dat1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy4 || busy1) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle bound", int'(n < 300), 1);
  endtask

  initial begin
    int         s, c0, r0, z;
    logic [7:0] rd;
    logic [19:0] a;
    adr = 20'h0; wdat = 8'h00; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset cs_n", cs4, 1);
    chk("reset sck", sck4, 0);
    chk("reset busy", busy4, 0);
    chk("reset rdata", dat4, 0);

    // 0xA5 at CLK_DIV=4 with CS asserted
    wb_issue(BASE4 + 20'd2, 1'b1, 8'h01, s);
    chk("cs_n after CONTROL=1", cs4, 0);
    c0 = bcnt4; r0 = rise4;
    wb_issue(BASE4, 1'b1, 8'hA5, s);
    wait_idle();
    chk("A5 rise count", rise4 - r0, 8);
    chk("A5 bits at rises", rbits4, 8'hA5);
    chk("A5 busy cycles", bcnt4 - c0, 64);
    wb_read(BASE4, rd);

    // Loopback 0x3C with STATUS polling
    loop4 = 1'b1;
    wb_issue(BASE4, 1'b1, 8'h3C, s);
    wb_read(BASE4 + 20'd1, rd);
    chk("status while busy", rd, 8'h01);
    for (int k = 0; k < 100 && rd[0]; k++) wb_read(BASE4 + 20'd1, rd);
    chk("status when done", rd, 8'h02);
    wb_read(BASE4, rd);
    chk("loopback data", rd, 8'h3C);
    wb_read(BASE4 + 20'd1, rd);
    chk("status after read", rd, 8'h00);
    loop4 = 1'b0;

    // Back-to-back DATA writes: the second one waits out the whole byte
    wb_issue(BASE4, 1'b1, 8'h11, s);
    wb_issue(BASE4, 1'b1, 8'h22, s);
    chk("second write stall cycles", s, 64);
    wb_read(BASE4 + 20'd1, rd);
    chk("status mid second byte", rd, 8'h03);
    wait_idle();
    wb_read(BASE4, rd);

    // Strobe held outside both windows
    repeat (2) @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; adr = BASE4 + 20'd4; we = 1'b1; wdat = 8'hFF;
    z = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack4 || ack1 || stall4 || stall1 || (dat4 != 8'h00) || (dat1 != 8'h00)) z++;
      @(posedge clk);
      #1;
      we = (k < 10);
    end
    cyc = 1'b0; stb = 1'b0;
    chk("out-of-window activity", z, 0);

    // Asynchronous reset in the high phase of bit 4
    wb_issue(BASE4 + 20'd2, 1'b1, 8'h01, s);
    wb_issue(BASE4, 1'b1, 8'h96, s);
    repeat (36) @(posedge clk);
    #3;
    chk("sck high before reset", sck4, 1);
    rst_n = 1'b0;
    #1;
    chk("sck on reset", sck4, 0);
    chk("cs_n on reset", cs4, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wb_read(BASE4 + 20'd1, rd);
    chk("status after reset", rd, 8'h00);
    wb_read(BASE4, rd);
    chk("data after reset", rd, 8'h00);

    // CLK_DIV=1: completion coinciding with a DATA read
    sd1_mode = 1;
    wb_issue(BASE1, 1'b1, 8'h5A, s);
    wait_idle();
    wb_read(BASE1, rd);
    chk("div1 zeros byte", rd, 8'h00);
    sd1_mode = 2;
    c0 = bcnt1; r0 = rise1;
    wb_issue(BASE1, 1'b1, 8'h00, s);
    repeat (15) @(posedge clk);
    #1;
    wb_read(BASE1, rd);
    chk("div1 read at completion", rd, 8'h00);
    chk("div1 busy cycles", bcnt1 - c0, 16);
    chk("div1 rise count", rise1 - r0, 8);
    wb_read(BASE1 + 20'd1, rd);
    chk("div1 status keeps rx_valid", rd, 8'h02);
    wb_read(BASE1, rd);
    chk("div1 data", rd, 8'hFF);
    wb_read(BASE1 + 20'd1, rd);
    chk("div1 status cleared", rd, 8'h00);
    sd1_mode = 0;

    // Random traffic to both instances and outside them
    for (int n = 0; n < 400; n++) begin
      int r, k;
      r = $urandom_range(0, 9);
      a = (r < 5) ? BASE4 : (r < 9) ? BASE1 : 20'h0F000;
      a[1:0] = 2'($urandom);
      wb_issue(a, 1'($urandom), 8'($urandom), s);
      k = $urandom_range(0, 3);
      if (k > 0) begin
        repeat (k) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
